ex_mem: RTL and testbench
=========================

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous active-low reset; rst=0 resets immediately, independent of clk.
REQ-003 SHALL have port flush_i  input  1  discard all buffered instructions.
REQ-004 SHALL have port ex_valid_i  input  1  EX presents an instruction.
REQ-005 SHALL have port ex_ready_o  output  1  block can accept an instruction.
REQ-006 SHALL have port ex_wd_i  input  5  destination register address.
REQ-007 SHALL have port ex_wreg_i  input  1  register write enable.
REQ-008 SHALL have port ex_wdata_i  input  32  result data.
REQ-009 SHALL have port ex_memop_i  input  4  memory-op code (0 = none).
REQ-010 SHALL have port ex_maddr_i  input  32  memory address.
REQ-011 SHALL have port ex_sdata_i  input  32  store data.
REQ-012 SHALL have port mem_valid_o  output  1  instruction presented to MEM.
REQ-013 SHALL have port mem_ready_i  input  1  MEM accepts this cycle.
REQ-014 SHALL have outputs mem_wd_o (5), mem_wreg_o (1), mem_wdata_o (32), mem_memop_o (4), mem_maddr_o (32), mem_sdata_o (32) mirroring the ex_* payload.

Function
REQ-015 SHALL transfer upstream when ex_valid_i=1 and ex_ready_o=1, and downstream when mem_valid_o=1 and mem_ready_i=1, each at the rising edge.
REQ-016 SHALL hold two payload entries, main and skid, and use a state register with states EMPTY, ONE and FULL.
REQ-017 SHALL drive mem_valid_o=1 in ONE and FULL, presenting main; SHALL drive ex_ready_o=1 in EMPTY and ONE.
REQ-018 SHALL derive ex_ready_o from the state register only, with no combinational path from mem_ready_i.
REQ-019 SHALL perform these transitions in EMPTY: on input, load main and go to ONE; otherwise stay.
REQ-020 SHALL perform these transitions in ONE: input and output, main takes the new entry and stays ONE; input only, skid takes it and goes to FULL; output only, goes to EMPTY; neither, stays ONE.
REQ-021 SHALL perform these transitions in FULL: on output, skid moves to main and goes to ONE; otherwise stays FULL.
REQ-022 SHALL give one-cycle latency: an entry accepted in EMPTY appears on mem_* the next cycle.
REQ-023 SHALL preserve program order, with no entry lost or duplicated under any ready/valid pattern.
REQ-024 SHALL hold mem_* payload stable while mem_valid_o=1 and mem_ready_i=0.
REQ-025 SHALL force mem_wd_o=0, mem_wreg_o=0, mem_wdata_o=0, mem_memop_o=0, mem_maddr_o=0 and mem_sdata_o=0 whenever mem_valid_o=0.
REQ-026 SHALL give flush_i=1 priority over all events: the next state is EMPTY, the same-cycle input is dropped and the downstream transfer is ignored.
REQ-027 SHALL keep ex_ready_o combinationally independent of flush_i.

Reset
REQ-028 SHALL enter EMPTY asynchronously on rst=0: mem_valid_o=0, ex_ready_o=1, all mem_* payload 0, both entries cleared.
REQ-029 SHALL discard in-flight entries on reset mid-operation; the first accept after rst returns high behaves as from EMPTY.

Configuration
REQ-030 SHALL, with macro EX_MEM_PERF_EN defined, add port stall_cnt_o  output  32, counting cycles with mem_valid_o=1 and mem_ready_i=0.
REQ-031 SHALL, with EX_MEM_PERF_EN defined, wrap stall_cnt_o from 0xFFFFFFFF to 0, clear it only on reset and leave it unaffected by flush_i.
REQ-032 SHALL, without EX_MEM_PERF_EN, omit stall_cnt_o and its logic entirely, with all other behaviour identical.

Verification
REQ-033 SHALL pass streaming: mem_ready_i=1, ex_valid_i=1 for 3 cycles with wdata 0x11, 0x22, 0x33 -> mem_wdata_o 0x11, 0x22, 0x33 on consecutive cycles, ex_ready_o constantly 1.
REQ-034 SHALL pass backpressure: mem_ready_i=0, push 0xA then 0xB -> FULL, ex_ready_o=0; third push 0xC held off; release mem_ready_i -> 0xA, 0xB, 0xC in order.
REQ-035 SHALL pass flush: FULL with 0xA/0xB, flush_i=1 with ex_valid_i=1 (0xC) -> next cycle mem_valid_o=0, mem_wreg_o=0, ex_ready_o=1, 0xC never emitted.
REQ-036 SHALL pass async reset: rst=0 asserted mid-cycle while FULL -> mem_valid_o=0 and all payload 0 before the next clk edge.
REQ-037 SHALL pass the perf counter (EX_MEM_PERF_EN defined): 5 cycles valid with mem_ready_i=0 -> stall_cnt_o=5; flush -> still 5; reset -> 0.

Source files
------------

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with a two-entry skid buffer (main + skid).
// Optional stall counter enabled by defining EX_MEM_PERF_EN.
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [3:0]  ex_memop_i,
  input  logic [31:0] ex_maddr_i,
  input  logic [31:0] ex_sdata_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [4:0]  mem_wd_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_memop_o,
  output logic [31:0] mem_maddr_o,
  output logic [31:0] mem_sdata_o
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [3:0]  memop;
    logic [31:0] maddr;
    logic [31:0] sdata;
  } payload_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t   state_q, state_d;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  payload_t in_p, out_p;
  logic     push, pop;

  assign in_p = '{wd: ex_wd_i, wreg: ex_wreg_i, wdata: ex_wdata_i,
                  memop: ex_memop_i, maddr: ex_maddr_i, sdata: ex_sdata_i};

  // Handshake signals come from the state register only, so neither
  // mem_ready_i nor flush_i reaches ex_ready_o combinationally.
  assign ex_ready_o  = (state_q != FULL);
  assign mem_valid_o = (state_q != EMPTY);
  assign push        = ex_valid_i & ex_ready_o;
  assign pop         = mem_valid_o & mem_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          main_d  = in_p;
          state_d = ONE;
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_p;
          end else if (push) begin
            skid_d  = in_p;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Payload is zeroed whenever nothing is presented downstream.
  assign out_p       = mem_valid_o ? main_q : '0;
  assign mem_wd_o    = out_p.wd;
  assign mem_wreg_o  = out_p.wreg;
  assign mem_wdata_o = out_p.wdata;
  assign mem_memop_o = out_p.memop;
  assign mem_maddr_o = out_p.maddr;
  assign mem_sdata_o = out_p.sdata;

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running, wraps naturally; flush does not touch it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_valid_o && !mem_ready_i) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: queue-based reference model plus directed cases.
module tb_ex_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, ex_valid_i, ex_ready_o, mem_valid_o, mem_ready_i;
  logic [4:0]  ex_wd_i, mem_wd_o;
  logic        ex_wreg_i, mem_wreg_o;
  logic [31:0] ex_wdata_i, mem_wdata_o, ex_maddr_i, mem_maddr_o, ex_sdata_i, mem_sdata_o;
  logic [3:0]  ex_memop_i, mem_memop_o;
`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  ex_mem dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .ex_memop_i(ex_memop_i), .ex_maddr_i(ex_maddr_i), .ex_sdata_i(ex_sdata_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
    .mem_memop_o(mem_memop_o), .mem_maddr_o(mem_maddr_o), .mem_sdata_o(mem_sdata_o)
`ifdef EX_MEM_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: FIFO of capacity 2; ready means "fewer than 2 held".
  logic [105:0] q[$];
  int unsigned  stall_m;

  function automatic logic [105:0] in_vec();
    return {ex_wd_i, ex_wreg_i, ex_wdata_i, ex_memop_i, ex_maddr_i, ex_sdata_i};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      stall_m = 0;
    end else begin
      automatic bit acc = ex_valid_i && (q.size() < 2);
      automatic bit dlv = (q.size() > 0) && mem_ready_i;
      if (q.size() > 0 && !mem_ready_i) stall_m++;
      if (flush_i) q.delete();
      else begin
        if (dlv) void'(q.pop_front());
        if (acc) q.push_back(in_vec());
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("model_valid", 128'(mem_valid_o), 128'(q.size() > 0));
      chk("model_ready", 128'(ex_ready_o), 128'(q.size() < 2));
      chk("model_payload",
          128'({mem_wd_o, mem_wreg_o, mem_wdata_o, mem_memop_o, mem_maddr_o, mem_sdata_o}),
          128'((q.size() > 0) ? q[0] : 106'd0));
`ifdef EX_MEM_PERF_EN
      chk("model_stall", 128'(stall_cnt_o), 128'(stall_m));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    ex_valid_i = v;
    ex_wdata_i = d;
    ex_wd_i    = d[4:0];
    ex_wreg_i  = 1'b1;
    ex_memop_i = d[3:0];
    ex_maddr_i = ~d;
    ex_sdata_i = d + 32'd1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush_i = 1'b0; mem_ready_i = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    chk("reset_valid", 128'(mem_valid_o), 128'(0));
    chk("reset_ready", 128'(ex_ready_o), 128'(1));
    chk("reset_payload", 128'({mem_wd_o, mem_wreg_o, mem_wdata_o, mem_memop_o, mem_maddr_o, mem_sdata_o}), 128'(0));
    @(posedge clk); #1 rst = 1'b1;

    // Streaming
    mem_ready_i = 1'b1;
    drive(1'b1, 32'h11); cyc();
    chk("stream_d0", 128'(mem_wdata_o), 128'h11); chk("stream_r0", 128'(ex_ready_o), 128'(1));
    drive(1'b1, 32'h22); cyc();
    chk("stream_d1", 128'(mem_wdata_o), 128'h22); chk("stream_r1", 128'(ex_ready_o), 128'(1));
    drive(1'b1, 32'h33); cyc();
    chk("stream_d2", 128'(mem_wdata_o), 128'h33); chk("stream_r2", 128'(ex_ready_o), 128'(1));
    drive(1'b0, 32'h0); cyc();
    chk("stream_drain", 128'(mem_valid_o), 128'(0));

    // Backpressure
    mem_ready_i = 1'b0;
    drive(1'b1, 32'hA); cyc();
    drive(1'b1, 32'hB); cyc();
    chk("bp_full_ready", 128'(ex_ready_o), 128'(0));
    chk("bp_head", 128'(mem_wdata_o), 128'hA);
    drive(1'b1, 32'hC); cyc();
    chk("bp_hold_head", 128'(mem_wdata_o), 128'hA);
    chk("bp_hold_sdata", 128'(mem_sdata_o), 128'hB);
    chk("bp_hold_ready", 128'(ex_ready_o), 128'(0));
    mem_ready_i = 1'b1; cyc();
    chk("bp_out1", 128'(mem_wdata_o), 128'hB);
    chk("bp_ready_back", 128'(ex_ready_o), 128'(1));
    cyc(); drive(1'b0, 32'h0);
    chk("bp_out2", 128'(mem_wdata_o), 128'hC);
    cyc();
    chk("bp_empty", 128'(mem_valid_o), 128'(0));

    // Flush while FULL with a same-cycle push
    mem_ready_i = 1'b0;
    drive(1'b1, 32'hA); cyc();
    drive(1'b1, 32'hB); cyc();
    flush_i = 1'b1; drive(1'b1, 32'hC); cyc();
    flush_i = 1'b0; drive(1'b0, 32'h0);
    chk("flush_valid", 128'(mem_valid_o), 128'(0));
    chk("flush_wreg", 128'(mem_wreg_o), 128'(0));
    chk("flush_ready", 128'(ex_ready_o), 128'(1));
    mem_ready_i = 1'b1; cyc();
    chk("flush_no_c", 128'(mem_valid_o), 128'(0));

    // Asynchronous reset mid-cycle while FULL
    mem_ready_i = 1'b0;
    drive(1'b1, 32'hA); cyc();
    drive(1'b1, 32'hB); cyc();
    drive(1'b0, 32'h0);
    #2 rst = 1'b0; #1;
    chk("arst_valid", 128'(mem_valid_o), 128'(0));
    chk("arst_ready", 128'(ex_ready_o), 128'(1));
    chk("arst_payload", 128'({mem_wd_o, mem_wreg_o, mem_wdata_o, mem_memop_o, mem_maddr_o, mem_sdata_o}), 128'(0));
    #1 rst = 1'b1;
    mem_ready_i = 1'b1;
    drive(1'b1, 32'h5A); cyc(); drive(1'b0, 32'h0);
    chk("arst_first", 128'(mem_wdata_o), 128'h5A);
    cyc();

`ifdef EX_MEM_PERF_EN
    do_reset();
    cyc();
    mem_ready_i = 1'b0;
    drive(1'b1, 32'h7); cyc(); drive(1'b0, 32'h0);
    repeat (5) cyc();
    chk("perf_five", 128'(stall_cnt_o), 128'(5));
    mem_ready_i = 1'b1; flush_i = 1'b1; cyc(); flush_i = 1'b0;
    chk("perf_flush", 128'(stall_cnt_o), 128'(5));
    do_reset();
    chk("perf_reset", 128'(stall_cnt_o), 128'(0));
    cyc();
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 99) < 65), $urandom);
      ex_wd_i    = 5'($urandom);
      ex_wreg_i  = 1'($urandom);
      ex_memop_i = 4'($urandom);
      ex_maddr_i = $urandom;
      mem_ready_i = 1'($urandom_range(0, 99) < 55);
      flush_i     = 1'($urandom_range(0, 99) < 4);
      if (i == 300) do_reset();
      cyc();
    end
    drive(1'b0, 32'h0); flush_i = 1'b0; mem_ready_i = 1'b1;
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
